umi_regif_pipe: RTL and testbench

- Pipelined, parametrised successor to the single-register UMI device interface.
- Translates UMI requests into a simple register read/write strobe interface.
- Accepts one request per cycle and supports a configurable register read latency.
- Buffers responses in a DEPTH-entry FIFO; returns correct UMI read and write responses; sinks posted writes without a response.

---
 rtl/umi_regif_pipe.sv | 183 ++++++++++++++++++
 tb/tb_umi_regif_pipe.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/umi_regif_pipe.sv
// Pipelined UMI-to-register bridge with RDLAT-deep read pipe and DEPTH-entry response FIFO.
// Optional macro UMI_REGIF_ERR_EN: read/write misses return all-ones responses instead of being dropped.
module umi_regif_pipe #(
    parameter int AW        = 64,
    parameter int CW        = 32,
    parameter int DW        = 256,
    parameter int RW        = 64,
    parameter int RDLAT     = 1,
    parameter int DEPTH     = 4,
    parameter int GRPOFFSET = 24,
    parameter int GRPAW     = 4,
    parameter int GRPID     = 0
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          udev_req_valid,
    input  logic [CW-1:0] udev_req_cmd,
    input  logic [AW-1:0] udev_req_dstaddr,
    input  logic [AW-1:0] udev_req_srcaddr,
    input  logic [DW-1:0] udev_req_data,
    output logic          udev_req_ready,
    output logic          udev_resp_valid,
    output logic [CW-1:0] udev_resp_cmd,
    output logic [AW-1:0] udev_resp_dstaddr,
    output logic [AW-1:0] udev_resp_srcaddr,
    output logic [DW-1:0] udev_resp_data,
    input  logic          udev_resp_ready,
    output logic [AW-1:0] reg_addr,
    output logic          reg_write,
    output logic          reg_read,
    output logic [7:0]    reg_cmd,
    output logic [3:0]    reg_size,
    output logic [RW-1:0] reg_wrdata,
    input  logic [RW-1:0] reg_rddata
);

    localparam int PW = $clog2(DEPTH) + 1;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0] MAXSIZE = 3'($clog2(RW / 8));
    localparam logic [4:0] UMI_REQ_READ   = 5'h01;
    localparam logic [4:0] UMI_REQ_WRITE  = 5'h03;
    localparam logic [4:0] UMI_REQ_POSTED = 5'h05;
    localparam logic [4:0] UMI_RESP_READ  = 5'h02;
    localparam logic [4:0] UMI_RESP_WRITE = 5'h04;

    typedef struct packed {
        logic          rd;
`ifdef UMI_REGIF_ERR_EN
        logic          err;
`endif
        logic [CW-1:0] cmd;
        logic [AW-1:0] src;
        logic [AW-1:0] dst;
    } meta_t;

    logic [4:0]    opcode;
    logic [2:0]    size;
    logic          op_rd, op_wr, op_po;
    logic          grp_hit, hit, accept;
    logic          vld_p0, vld_px;
    meta_t         meta_p0, meta_px;
    logic [PW-1:0] credits;
    logic          init_done;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          pop;
    logic [CW-1:0] push_cmd;
    logic [DW-1:0] push_data;

    logic [CW-1:0] cmd_mem  [DEPTH];
    logic [AW-1:0] dst_mem  [DEPTH];
    logic [AW-1:0] src_mem  [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];

    // Stage p0: decode and strobe generation in the accept cycle
    assign opcode  = udev_req_cmd[4:0];
    assign size    = udev_req_cmd[7:5];
    assign op_rd   = (opcode == UMI_REQ_READ);
    assign op_wr   = (opcode == UMI_REQ_WRITE);
    assign op_po   = (opcode == UMI_REQ_POSTED);
    assign grp_hit = (udev_req_dstaddr[GRPOFFSET +: GRPAW] == GRPAW'(GRPID));
    assign hit     = grp_hit & (size <= MAXSIZE) & (op_rd | op_wr | op_po);

    // Ready is derived from registered state only, never from udev_req_valid
    assign udev_req_ready = init_done & (credits < PW'(DEPTH));
    assign accept         = udev_req_valid & udev_req_ready;

    assign reg_read   = accept & hit & op_rd;
    assign reg_write  = accept & hit & (op_wr | op_po);
    assign reg_addr   = udev_req_dstaddr;
    assign reg_cmd    = {3'b000, opcode};
    assign reg_size   = {1'b0, size};
    assign reg_wrdata = udev_req_data[RW-1:0];

`ifdef UMI_REGIF_ERR_EN
    assign vld_p0      = accept & (op_rd | op_wr);
    assign meta_p0.err = ~hit;
`else
    assign vld_p0      = accept & hit & (op_rd | op_wr);
`endif
    assign meta_p0.rd  = op_rd;
    assign meta_p0.cmd = udev_req_cmd;
    assign meta_p0.src = udev_req_srcaddr;
    assign meta_p0.dst = udev_req_dstaddr;

    // Stages p1/p2: align response metadata with reg_rddata
    generate
        if (RDLAT == 0) begin : g_lat0
            assign vld_px  = vld_p0;
            assign meta_px = meta_p0;
        end else if (RDLAT == 1) begin : g_lat1
            logic  vld_p1;
            meta_t meta_p1;
            always_ff @(posedge clk or negedge nreset) begin
                if (!nreset) vld_p1 <= 1'b0;
                else         vld_p1 <= vld_p0;
            end
            always_ff @(posedge clk) begin
                meta_p1 <= meta_p0;
            end
            assign vld_px  = vld_p1;
            assign meta_px = meta_p1;
        end else begin : g_lat2
            logic  vld_p1, vld_p2;
            meta_t meta_p1, meta_p2;
            always_ff @(posedge clk or negedge nreset) begin
                if (!nreset) begin
                    vld_p1 <= 1'b0;
                    vld_p2 <= 1'b0;
                end else begin
                    vld_p1 <= vld_p0;
                    vld_p2 <= vld_p1;
                end
            end
            always_ff @(posedge clk) begin
                meta_p1 <= meta_p0;
                meta_p2 <= meta_p1;
            end
            assign vld_px  = vld_p2;
            assign meta_px = meta_p2;
        end
    endgenerate

    // Pipe exit: build the response that enters the FIFO
    always_comb begin
        push_cmd  = {meta_px.cmd[CW-1:5], meta_px.rd ? UMI_RESP_READ : UMI_RESP_WRITE};
        push_data = meta_px.rd ? {(DW / RW){reg_rddata}} : '0;
`ifdef UMI_REGIF_ERR_EN
        if (meta_px.err) push_data = '1;
`endif
    end

    assign udev_resp_valid   = (wr_ptr != rd_ptr);
    assign pop               = udev_resp_valid & udev_resp_ready;
    assign udev_resp_cmd     = cmd_mem[IW'(rd_ptr)];
    assign udev_resp_dstaddr = dst_mem[IW'(rd_ptr)];
    assign udev_resp_srcaddr = src_mem[IW'(rd_ptr)];
    assign udev_resp_data    = data_mem[IW'(rd_ptr)];

    // Credits cover FIFO occupancy plus pipe contents, so a push never overflows
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            init_done <= 1'b0;
            credits   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
        end else begin
            init_done <= 1'b1;
            credits   <= credits + PW'(vld_p0) - PW'(pop);
            if (vld_px) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (vld_px) begin
            cmd_mem[IW'(wr_ptr)]  <= push_cmd;
            dst_mem[IW'(wr_ptr)]  <= meta_px.src;
            src_mem[IW'(wr_ptr)]  <= meta_px.dst;
            data_mem[IW'(wr_ptr)] <= push_data;
        end
    end

endmodule

// File: tb/tb_umi_regif_pipe.sv
// Directed self-checking bench for umi_regif_pipe at default parameters (RDLAT=1, DEPTH=4).
module tb_umi_regif_pipe;

    logic         clk = 1'b0;
    logic         nreset;
    logic         udev_req_valid;
    logic [31:0]  udev_req_cmd;
    logic [63:0]  udev_req_dstaddr;
    logic [63:0]  udev_req_srcaddr;
    logic [255:0] udev_req_data;
    logic         udev_req_ready;
    logic         udev_resp_valid;
    logic [31:0]  udev_resp_cmd;
    logic [63:0]  udev_resp_dstaddr;
    logic [63:0]  udev_resp_srcaddr;
    logic [255:0] udev_resp_data;
    logic         udev_resp_ready;
    logic [63:0]  reg_addr;
    logic         reg_write;
    logic         reg_read;
    logic [7:0]   reg_cmd;
    logic [3:0]   reg_size;
    logic [63:0]  reg_wrdata;
    logic [63:0]  reg_rddata;

    localparam logic [31:0] C_READ   = 32'h61;
    localparam logic [31:0] C_WRITE  = 32'h63;
    localparam logic [31:0] C_POSTED = 32'h65;
    localparam logic [31:0] R_READ   = 32'h62;
    localparam logic [31:0] R_WRITE  = 32'h64;

    umi_regif_pipe dut (
        .clk(clk), .nreset(nreset),
        .udev_req_valid(udev_req_valid), .udev_req_cmd(udev_req_cmd),
        .udev_req_dstaddr(udev_req_dstaddr), .udev_req_srcaddr(udev_req_srcaddr),
        .udev_req_data(udev_req_data), .udev_req_ready(udev_req_ready),
        .udev_resp_valid(udev_resp_valid), .udev_resp_cmd(udev_resp_cmd),
        .udev_resp_dstaddr(udev_resp_dstaddr), .udev_resp_srcaddr(udev_resp_srcaddr),
        .udev_resp_data(udev_resp_data), .udev_resp_ready(udev_resp_ready),
        .reg_addr(reg_addr), .reg_write(reg_write), .reg_read(reg_read),
        .reg_cmd(reg_cmd), .reg_size(reg_size), .reg_wrdata(reg_wrdata),
        .reg_rddata(reg_rddata)
    );

    always #5 clk = ~clk;

    // Register file model: fixed contents, data returned one cycle after reg_read
    function automatic logic [63:0] regval(input logic [63:0] a);
        return 64'h1122334455667788 + a - 64'h10;
    endfunction

    always @(posedge clk) if (reg_read) reg_rddata <= regval(reg_addr);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0]  cmd;
        logic [63:0]  dst;
        logic [63:0]  src;
        logic [255:0] data;
        int           cyc;
    } rsp_t;
    rsp_t q[$];

    always @(negedge clk) begin
        if (nreset && udev_resp_valid && udev_resp_ready)
            q.push_back('{udev_resp_cmd, udev_resp_dstaddr, udev_resp_srcaddr, udev_resp_data, cyc});
    end

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_begin(input logic [31:0] c, input logic [63:0] d, input logic [63:0] s,
                              input logic [255:0] dat);
        int n;
        @(posedge clk); #1;
        udev_req_cmd = c; udev_req_dstaddr = d; udev_req_srcaddr = s; udev_req_data = dat;
        udev_req_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!udev_req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("accept_timeout", 1'b0, 1'b1);
    endtask

    task automatic send_end();
        @(posedge clk); #1;
        udev_req_valid = 1'b0;
    endtask

    task automatic wait_resp(input int n);
        int k;
        k = 0;
        while (q.size() < n && k < 100) begin
            @(negedge clk); #1;
            k++;
        end
        chk("resp_count", q.size(), n);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [63:0] a;
    int idx;

    initial begin
        nreset = 1'b0; udev_req_valid = 1'b0; udev_req_cmd = '0;
        udev_req_dstaddr = '0; udev_req_srcaddr = '0; udev_req_data = '0;
        udev_resp_ready = 1'b1; reg_rddata = '0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", udev_req_ready, 1'b0);
        chk("rst_resp_valid", udev_resp_valid, 1'b0);
        @(posedge clk); #1 nreset = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("ready_after_rst", udev_req_ready, 1'b1);

        // single read
        send_begin(C_READ, 64'h10, 64'hABC, '0);
        chk("rd_strobe", reg_read, 1'b1);
        chk("rd_addr", reg_addr, 64'h10);
        chk("rd_no_write", reg_write, 1'b0);
        send_end();
        @(negedge clk);
        chk("rd_strobe_pulse", reg_read, 1'b0);
        wait_resp(1);
        if (q.size() >= 1) begin
            chk("rd_resp_cmd", q[0].cmd, R_READ);
            chk("rd_resp_dst", q[0].dst, 64'hABC);
            chk("rd_resp_src", q[0].src, 64'h10);
            chk("rd_resp_data", q[0].data, {4{64'h1122334455667788}});
        end
        q.delete();

        // back-to-back reads
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            udev_req_cmd = C_READ; udev_req_dstaddr = 64'h20 + 64'(8 * i);
            udev_req_srcaddr = 64'h100 + 64'(i); udev_req_valid = 1'b1;
            @(negedge clk);
            chk("b2b_ready", udev_req_ready, 1'b1);
            chk("b2b_strobe", reg_read, 1'b1);
        end
        @(posedge clk); #1 udev_req_valid = 1'b0;
        wait_resp(8);
        for (int i = 0; i < 8 && i < q.size(); i++) begin
            a = 64'h20 + 64'(8 * i);
            chk("b2b_cmd", q[i].cmd, R_READ);
            chk("b2b_dst", q[i].dst, 64'h100 + 64'(i));
            chk("b2b_data", q[i].data, {4{regval(a)}});
            if (i > 0) chk("b2b_consecutive", q[i].cyc - q[i-1].cyc, 1);
        end
        q.delete();

        // backpressure with six writes
        @(posedge clk); #1 udev_resp_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (idx < 6) begin
                udev_req_cmd = C_WRITE; udev_req_dstaddr = 64'h200 + 64'(idx);
                udev_req_srcaddr = 64'h300 + 64'(idx); udev_req_data = 256'(idx + 1);
                udev_req_valid = 1'b1;
            end else udev_req_valid = 1'b0;
            @(negedge clk);
            if (udev_req_valid && udev_req_ready) idx++;
        end
        chk("bp_accepted", idx, 4);
        chk("bp_ready_low", udev_req_ready, 1'b0);
        chk("bp_resp_valid", udev_resp_valid, 1'b1);
        chk("bp_no_pop", q.size(), 0);
        @(posedge clk); #1 udev_resp_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (idx < 6) begin
                udev_req_cmd = C_WRITE; udev_req_dstaddr = 64'h200 + 64'(idx);
                udev_req_srcaddr = 64'h300 + 64'(idx); udev_req_data = 256'(idx + 1);
                udev_req_valid = 1'b1;
            end else udev_req_valid = 1'b0;
            @(negedge clk);
            if (udev_req_valid && udev_req_ready) idx++;
        end
        chk("bp_all_accepted", idx, 6);
        wait_resp(6);
        for (int i = 0; i < 6 && i < q.size(); i++) begin
            chk("bp_cmd", q[i].cmd, R_WRITE);
            chk("bp_dst", q[i].dst, 64'h300 + 64'(i));
            chk("bp_src", q[i].src, 64'h200 + 64'(i));
            chk("bp_data", q[i].data, '0);
        end
        q.delete();

        // posted write
        send_begin(C_POSTED, 64'h50, 64'h99, 256'h55);
        chk("po_write", reg_write, 1'b1);
        chk("po_wrdata", reg_wrdata, 64'h55);
        chk("po_no_read", reg_read, 1'b0);
        send_end();
        repeat (10) @(negedge clk);
        chk("po_no_resp", q.size(), 0);
        chk("po_ready", udev_req_ready, 1'b1);

        // group miss
        send_begin(C_READ, 64'h0100_0030, 64'h123, '0);
        chk("miss_no_read", reg_read, 1'b0);
        send_end();
        repeat (10) @(negedge clk);
`ifdef UMI_REGIF_ERR_EN
        chk("miss_err_resp", q.size(), 1);
        if (q.size() >= 1) begin
            chk("miss_cmd", q[0].cmd, R_READ);
            chk("miss_dst", q[0].dst, 64'h123);
            chk("miss_data", q[0].data, {256{1'b1}});
        end
`else
        chk("miss_no_resp", q.size(), 0);
`endif
        q.delete();

        // reset with three buffered responses
        @(posedge clk); #1 udev_resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send_begin(C_READ, 64'h60 + 64'(8 * i), 64'h500 + 64'(i), '0);
            send_end();
        end
        repeat (3) @(negedge clk);
        chk("mid_buffered", udev_resp_valid, 1'b1);
        #2 nreset = 1'b0;
        #1;
        chk("mid_rst_valid", udev_resp_valid, 1'b0);
        chk("mid_rst_ready", udev_req_ready, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk); #1 nreset = 1'b1; udev_resp_ready = 1'b1;
        repeat (10) @(negedge clk);
        chk("mid_no_stale", q.size(), 0);
        send_begin(C_READ, 64'h40, 64'h77, '0);
        send_end();
        wait_resp(1);
        if (q.size() >= 1) begin
            chk("post_rst_dst", q[0].dst, 64'h77);
            chk("post_rst_data", q[0].data, {4{64'h11223344556677B8}});
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
